// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game sequencer and the blocks that consume its
// outputs (pixel compositor, sprite logic).
//   - game_state_e : 4-bit game phase encoding driven on the `state` bus.
//                    Codes 6..15 are unused and are treated as illegal.
//   - LIVES_W      : width of the lives count.
//   - CNT_W        : width of the frame countdown.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int STATE_W = 4;
    localparam int LIVES_W = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_TITLE = 4'd0,
        ST_READY = 4'd1,
        ST_PLAY  = 4'd2,
        ST_PAUSE = 4'd3,
        ST_HIT   = 4'd4,
        ST_OVER  = 4'd5
    } game_state_e;

endpackage

// File: rtl/edge_latch.sv
// ---------------------------------------------------------------------------
// edge_latch
// Turns an input into a per-frame event request. In edge mode a rising edge
// of `in` is the event; in level mode every high cycle of `in` is an event
// (used for inputs that are already single-cycle pulses). An event sets a
// sticky flag that survives until `clr`.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in          input level or pulse
//   level_mode  1: pass pulses straight through, 0: rising-edge detect
//   clr         clears the sticky flag (the consumer's evaluation strobe)
//   pend        sticky flag OR the event seen in this same cycle, so an event
//               coinciding with `clr` is still visible to the consumer
// ---------------------------------------------------------------------------
module edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic level_mode,
    input  logic clr,
    output logic pend
);

    logic prev_q;
    logic pend_q;
    logic evt;

    assign evt = level_mode ? in : (in & ~prev_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= in;
            // Clearing wins: an event in the clr cycle is consumed through
            // the combinational path below and must not leak into the next
            // frame.
            pend_q <= clr ? 1'b0 : (pend_q | evt);
        end
    end

    assign pend = pend_q | evt;

endmodule

// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
// Frame-synchronous game sequencer. Player inputs and game events are latched
// during a frame and acted on only at frame_tick, so every output changes in
// the cycle after a tick and holds otherwise; the compositor never switches
// image source mid-frame.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset (aborts to TITLE at once)
//   frame_tick  one-cycle pulse at the start of vblank
//   btn_start   debounced start button level (rising edge = press)
//   btn_pause   debounced pause button level (rising edge = press)
//   player_hit  one-cycle pulse from collision logic
//   state       game phase (game_pkg::game_state_e encoding)
//   lives       remaining lives
//   phase_cnt   frames remaining in the current timed phase
//   flash       player blink enable (HIT phase, phase_cnt bit 3)
//
// Build option:
//   GAME_CTRL_PAUSE_EN  when defined, btn_pause is captured and the PAUSE
//                       phase is reachable. When undefined, btn_pause is
//                       ignored and code 3 is treated as illegal.
// ---------------------------------------------------------------------------
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int READY_FRAMES = 120,
    parameter int HIT_FRAMES   = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               player_hit,
    output logic [STATE_W-1:0] state,
    output logic [LIVES_W-1:0] lives,
    output logic [CNT_W-1:0]   phase_cnt,
    output logic               flash
);

`ifdef GAME_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
    localparam logic [CNT_W-1:0]   READY_LOAD = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0]   HIT_LOAD   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   OVER_LOAD  = CNT_W'(OVER_FRAMES - 1);

    // -----------------------------------------------------------------------
    // Event capture. All flags are cleared by frame_tick, consumed or not.
    // -----------------------------------------------------------------------
    logic start_p;
    logic pause_raw;
    logic pause_p;
    logic hit_p;

    edge_latch u_start (
        .clk        (clk),
        .rst        (rst),
        .in         (btn_start),
        .level_mode (1'b0),
        .clr        (frame_tick),
        .pend       (start_p)
    );

    edge_latch u_pause (
        .clk        (clk),
        .rst        (rst),
        .in         (btn_pause & PAUSE_EN),
        .level_mode (1'b0),
        .clr        (frame_tick),
        .pend       (pause_raw)
    );

    edge_latch u_hit (
        .clk        (clk),
        .rst        (rst),
        .in         (player_hit),
        .level_mode (1'b1),
        .clr        (frame_tick),
        .pend       (hit_p)
    );

    assign pause_p = pause_raw & PAUSE_EN;

    // -----------------------------------------------------------------------
    // Phase FSM with its datapath registers.
    // -----------------------------------------------------------------------
    game_state_e        state_q, state_n;
    logic [LIVES_W-1:0] lives_q, lives_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               flash_q, flash_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_TITLE;
            lives_q <= '0;
            cnt_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_n;
            lives_q <= lives_n;
            cnt_q   <= cnt_n;
            flash_q <= flash_n;
        end
    end

    always_comb begin
        state_n = state_q;
        lives_n = lives_q;
        cnt_n   = cnt_q;

        if (frame_tick) begin
            case (state_q)
                ST_TITLE: begin
                    if (start_p) begin
                        state_n = ST_READY;
                        lives_n = LIVES_LOAD;
                        cnt_n   = READY_LOAD;
                    end
                end

                ST_READY: begin
                    if (cnt_q == '0) state_n = ST_PLAY;
                    else             cnt_n   = cnt_q - CNT_W'(1);
                end

                ST_PLAY: begin
                    // A hit outranks a pause requested in the same frame.
                    if (hit_p) begin
                        if (lives_q == LIVES_W'(1)) begin
                            state_n = ST_OVER;
                            lives_n = '0;
                            cnt_n   = OVER_LOAD;
                        end else begin
                            state_n = ST_HIT;
                            lives_n = lives_q - LIVES_W'(1);
                            cnt_n   = HIT_LOAD;
                        end
                    end else if (pause_p) begin
                        state_n = ST_PAUSE;
                    end
                end

`ifdef GAME_CTRL_PAUSE_EN
                ST_PAUSE: begin
                    if (pause_p) state_n = ST_PLAY;
                end
`endif

                ST_HIT: begin
                    if (cnt_q == '0) state_n = ST_PLAY;
                    else             cnt_n   = cnt_q - CNT_W'(1);
                end

                ST_OVER: begin
                    if (start_p || cnt_q == '0) begin
                        state_n = ST_TITLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end

                // Unused codes (and PAUSE when it is compiled out) fall back
                // to the title screen.
                default: begin
                    state_n = ST_TITLE;
                    cnt_n   = '0;
                end
            endcase
        end

        flash_n = (state_n == ST_HIT) && cnt_n[3];
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign phase_cnt = cnt_q;
    assign flash     = flash_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
// Randomized and directed stimulus for game_state_ctrl. A reference model of
// the game rules predicts each frame's outcome, which is queued when the tick
// is driven; a separate monitor pops and compares after every tick.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

    localparam int LIVES_INIT   = 3;
    localparam int READY_FRAMES = 120;
    localparam int HIT_FRAMES   = 60;
    localparam int OVER_FRAMES  = 180;

`ifdef GAME_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    // Phase codes as the compositor sees them.
    localparam int TITLE = 0;
    localparam int READY = 1;
    localparam int PLAY  = 2;
    localparam int PAUSE = 3;
    localparam int HIT   = 4;
    localparam int OVER  = 5;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_pause;
    logic       player_hit;
    logic [3:0] state;
    logic [1:0] lives;
    logic [7:0] phase_cnt;
    logic       flash;

    game_state_ctrl #(
        .LIVES_INIT   (LIVES_INIT),
        .READY_FRAMES (READY_FRAMES),
        .HIT_FRAMES   (HIT_FRAMES),
        .OVER_FRAMES  (OVER_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .player_hit (player_hit),
        .state      (state),
        .lives      (lives),
        .phase_cnt  (phase_cnt),
        .flash      (flash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Scoreboard state and reference model
    // -----------------------------------------------------------------------
    logic [14:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    int m_state, m_lives, m_cnt;
    bit m_start, m_pause, m_hit;     // events seen this frame
    bit m_prev_s, m_prev_p;          // last driven button levels
    bit s_lvl, p_lvl;                // button levels held by the scenario

    function automatic logic [14:0] model_out();
        logic [3:0] st;
        logic [1:0] lv;
        logic [7:0] ct;
        logic       fl;
        st = m_state[3:0];
        lv = m_lives[1:0];
        ct = m_cnt[7:0];
        fl = (m_state == HIT) && ((m_cnt / 8) % 2 == 1);
        return {st, lv, ct, fl};
    endfunction

    function automatic void model_reset();
        m_state  = TITLE;
        m_lives  = 0;
        m_cnt    = 0;
        m_start  = 0;
        m_pause  = 0;
        m_hit    = 0;
        m_prev_s = 0;
        m_prev_p = 0;
    endfunction

    // One frame's worth of game rules, applied at a tick.
    function automatic void model_tick();
        case (m_state)
            TITLE: if (m_start) begin
                m_state = READY; m_lives = LIVES_INIT; m_cnt = READY_FRAMES - 1;
            end
            READY: if (m_cnt == 0) m_state = PLAY; else m_cnt = m_cnt - 1;
            PLAY: begin
                if (m_hit) begin
                    if (m_lives == 1) begin
                        m_state = OVER; m_lives = 0; m_cnt = OVER_FRAMES - 1;
                    end else begin
                        m_state = HIT; m_lives = m_lives - 1; m_cnt = HIT_FRAMES - 1;
                    end
                end else if (m_pause) begin
                    m_state = PAUSE;
                end
            end
            PAUSE: if (m_pause) m_state = PLAY;
            HIT: if (m_cnt == 0) m_state = PLAY; else m_cnt = m_cnt - 1;
            OVER: begin
                if (m_start || m_cnt == 0) begin
                    m_state = TITLE; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            default: begin m_state = TITLE; m_cnt = 0; end
        endcase
    endfunction

    function automatic void compare(input string name, input logic [14:0] got,
                                    input logic [14:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got state=%0d lives=%0d cnt=%0d flash=%0d, expected state=%0d lives=%0d cnt=%0d flash=%0d",
                     name, $time, got[14:11], got[10:9], got[8:1], got[0],
                     exp[14:11], exp[10:9], exp[8:1], exp[0]);
        end
    endfunction

    function automatic void check_now(input string name);
        compare(name, {state, lives, phase_cnt, flash}, model_out());
    endfunction

    // -----------------------------------------------------------------------
    // Monitor: every tick produces one expected outcome, visible next cycle.
    // -----------------------------------------------------------------------
    always begin
        @(posedge clk);
        if (frame_tick && !rst) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL tick_no_expectation @%0t: got state=%0d, expected an entry in the queue",
                         $time, state);
            end else begin
                compare("tick", {state, lives, phase_cnt, flash}, exp_q.pop_front());
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks. Called at a negedge; drive one cycle, return at the next.
    // -----------------------------------------------------------------------
    task automatic step(input bit s, input bit p, input bit h, input bit t);
        btn_start  = s;
        btn_pause  = p;
        player_hit = h;
        frame_tick = t;
        if (s && !m_prev_s) m_start = 1;
        if (p && !m_prev_p && PAUSE_EN) m_pause = 1;
        if (h) m_hit = 1;
        m_prev_s = s;
        m_prev_p = p;
        if (t) begin
            model_tick();
            exp_q.push_back(model_out());
            m_start = 0;
            m_pause = 0;
            m_hit   = 0;
        end
        @(negedge clk);
    endtask

    // Two-cycle frames; optional random hit pulses in the non-tick cycle.
    task automatic frames(input int n, input bit hit_noise);
        for (int i = 0; i < n; i++) begin
            step(s_lvl, p_lvl, hit_noise && ($urandom_range(0, 3) == 0), 1'b0);
            step(s_lvl, p_lvl, 1'b0, 1'b1);
        end
    endtask

    // Run frames until the model reaches a phase; overrun counts as a failure.
    task automatic run_until(input int st, input int max_frames, input bit hit_noise);
        int k;
        k = 0;
        while (m_state != st && k < max_frames) begin
            frames(1, hit_noise);
            k++;
        end
        if (m_state != st) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_until: got model state=%0d after %0d frames, expected state=%0d",
                     m_state, k, st);
        end
    endtask

    task automatic press_frame(input bit s, input bit p, input bit h);
        step(s, p, h, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic async_reset_check();
        #2;
        rst        = 1'b1;
        btn_start  = 1'b0;
        btn_pause  = 1'b0;
        player_hit = 1'b0;
        frame_tick = 1'b0;
        s_lvl      = 1'b0;
        p_lvl      = 1'b0;
        #1;
        model_reset();
        check_now("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_now("reset_hold_1");
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_now("reset_hold_2");
    endtask

    // -----------------------------------------------------------------------
    // Scenario
    // -----------------------------------------------------------------------
    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        btn_pause  = 1'b0;
        player_hit = 1'b0;
        s_lvl      = 1'b0;
        p_lvl      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_now("reset_init");
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_now("reset_release");

        // TITLE ignores hits and pause presses.
        frames(3, 1'b1);
        p_lvl = 1'b1;
        frames(1, 1'b1);
        p_lvl = 1'b0;
        frames(1, 1'b0);

        // Start held across five ticks: exactly one transition to READY.
        s_lvl = 1'b1;
        frames(5, 1'b0);
        s_lvl = 1'b0;
        run_until(PLAY, 130, 1'b1);

        // Hit with three lives, ignored hits during HIT, back to PLAY.
        press_frame(1'b0, 1'b0, 1'b1);
        run_until(PLAY, 70, 1'b1);

        // Pause round trip (stays in PLAY when pause is compiled out).
        press_frame(1'b0, 1'b1, 1'b0);
        frames(50, 1'b0);
        press_frame(1'b0, 1'b1, 1'b0);
        frames(2, 1'b0);

        // Asynchronous reset in the middle of PLAY with two lives left.
        async_reset_check();

        // Start press coinciding with the tick is acted on at that tick.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        run_until(PLAY, 130, 1'b0);
        for (int i = 0; i < 2; i++) begin
            press_frame(1'b0, 1'b0, 1'b1);
            run_until(PLAY, 70, 1'b0);
        end
        // Last life: hit and pause in the same frame, hit wins.
        press_frame(1'b0, 1'b1, 1'b1);
        run_until(TITLE, 190, 1'b0);

        // Game over cut short by start on the tenth OVER tick.
        press_frame(1'b1, 1'b0, 1'b0);
        run_until(PLAY, 130, 1'b0);
        for (int i = 0; i < 3; i++) begin
            press_frame(1'b0, 1'b0, 1'b1);
            if (m_state == HIT) run_until(PLAY, 70, 1'b0);
        end
        frames(9, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random play: frame lengths 1..4 cycles, random buttons and hits.
        for (int f = 0; f < 700; f++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 11) == 0) s_lvl = ~s_lvl;
                if ($urandom_range(0, 5) == 0)  p_lvl = ~p_lvl;
                step(s_lvl, p_lvl, $urandom_range(0, 7) == 0, c == len - 1);
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d outstanding expectations, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
